// File: rtl/rc_fetch_pkg.sv
// Shared definitions for the relational-cache column fetch path: sizing
// constants, FSM state type, the request payload and a lane-search helper.
package rc_fetch_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned MEM_DATA_W = 128;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned MAX_BEATS  = 8;

  localparam int unsigned BEAT_BYTES = MEM_DATA_W / 8;
  localparam int unsigned BEAT_SH    = $clog2(BEAT_BYTES);
  localparam int unsigned BUF_BYTES  = MAX_BEATS * BEAT_BYTES;
  localparam int unsigned BUF_W      = BUF_BYTES * 8;
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned LANE_W     = $clog2(LINE_BYTES);
  localparam int unsigned SIZE_W     = 7;
  localparam int unsigned IDX_W      = 7;
  localparam int unsigned WSIZE_W    = 16;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned BEAT_IDX_W = $clog2(MAX_BEATS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_PACK  = 3'd3,
    ST_WRITE = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]     r_addr;
    logic [SIZE_W-1:0]     r_size;
    logic [IDX_W-1:0]      r_start;
    logic [IDX_W-1:0]      r_end;
    logic [ADDR_W-1:0]     w_addr;
    logic [WSIZE_W-1:0]    w_size;
    logic [LINE_BYTES-1:0] w_strb;
  } fetch_req_t;

  // Index of the lowest set lane; zero when no lane is set.
  function automatic logic [LANE_W-1:0] lowest_set(input logic [LINE_BYTES-1:0] v);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (!found && v[i]) begin
        lowest_set = LANE_W'(i);
        found      = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/fetch_byte_packer.sv
// Combinational byte packer: maps the buffered read window onto the enabled
// lanes of a cache line. The lowest enabled lane receives byte r_start and
// each higher lane j receives byte r_start + (j - lowest); bytes past r_end
// and disabled lanes are zero.
//   buffer  : read buffer, byte 0 in bits [7:0]
//   r_start : first window byte index
//   r_end   : last window byte index (inclusive)
//   strb    : cache line byte enables
//   data    : packed cache line
module fetch_byte_packer
  import rc_fetch_pkg::*;
(
  input  logic [BUF_W-1:0]      buffer,
  input  logic [IDX_W-1:0]      r_start,
  input  logic [IDX_W-1:0]      r_end,
  input  logic [LINE_BYTES-1:0] strb,
  output logic [LINE_W-1:0]     data
);

  logic [LANE_W-1:0] low;
  logic [IDX_W:0]    src;

  // One extra index bit so start + lane offset cannot wrap before the end test.
  always_comb begin
    low  = lowest_set(strb);
    data = '0;
    src  = '0;
    for (int j = 0; j < LINE_BYTES; j++) begin
      src = (IDX_W+1)'(r_start) + (IDX_W+1)'(j) - (IDX_W+1)'(low);
      if (strb[j] && (src <= (IDX_W+1)'(r_end))) begin
        data[8*j +: 8] = buffer[8*int'(src[IDX_W-1:0]) +: 8];
      end
    end
  end

endmodule

// File: rtl/trid_fetch_unit.sv
// Per-transaction-ID column fetch unit. Accepts a request on i_en, issues a
// burst read, buffers the returned beats, packs the requested byte window
// into a 64-byte line and writes it to the cache.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_en, i_r_*, i_w_*       : request strobe and request fields
//   o_ready                  : idle, request can be accepted
//   o_ar_* / i_ar_ready      : burst read address channel
//   i_r_* / o_r_ready        : read data channel
//   o_wr_* / i_wr_ready      : cache line write channel
//   o_err                    : one-cycle range/protocol error pulse
module trid_fetch_unit
  import rc_fetch_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [ADDR_W-1:0]     i_r_addr,
  input  logic [SIZE_W-1:0]     i_r_size,
  input  logic [IDX_W-1:0]      i_r_start,
  input  logic [IDX_W-1:0]      i_r_end,
  input  logic [ADDR_W-1:0]     i_w_addr,
  input  logic [WSIZE_W-1:0]    i_w_size,
  input  logic [LINE_BYTES-1:0] i_w_strb,
  output logic                  o_ready,
  output logic                  o_ar_valid,
  input  logic                  i_ar_ready,
  output logic [ADDR_W-1:0]     o_ar_addr,
  output logic [LEN_W-1:0]      o_ar_len,
  input  logic                  i_r_valid,
  output logic                  o_r_ready,
  input  logic [MEM_DATA_W-1:0] i_r_data,
  input  logic                  i_r_last,
  output logic                  o_wr_valid,
  input  logic                  i_wr_ready,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [LINE_W-1:0]     o_wr_data,
  output logic [LINE_BYTES-1:0] o_wr_strb,
  output logic                  o_err
);

  fetch_state_t          state_q, state_d;
  fetch_req_t            req_q, req_d, req_in;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [BUF_W-1:0]      buf_q;
  logic [LINE_W-1:0]     packed_data;
  logic                  buf_we;
  logic                  req_ok, final_beat, size_mismatch;

  logic                  ready_d, ar_valid_d, r_ready_d, wr_valid_d, err_d;
  logic [ADDR_W-1:0]     ar_addr_d, wr_addr_d;
  logic [LEN_W-1:0]      ar_len_d;
  logic [LINE_W-1:0]     wr_data_d;
  logic [LINE_BYTES-1:0] wr_strb_d;

  assign req_in = '{r_addr: i_r_addr, r_size: i_r_size, r_start: i_r_start,
                    r_end: i_r_end, w_addr: i_w_addr, w_size: i_w_size,
                    w_strb: i_w_strb};

  // Reject empty/oversized bursts, inverted windows, windows past the burst
  // and windows wider than a cache line.
  assign req_ok = (i_r_size != '0)
               && (i_r_size <= SIZE_W'(MAX_BEATS))
               && (i_r_end >= i_r_start)
               && ({{BEAT_SH{1'b0}}, i_r_end} < {i_r_size, {BEAT_SH{1'b0}}})
               && ((i_r_end - i_r_start) < IDX_W'(LINE_BYTES));

  assign final_beat    = (SIZE_W'(beat_cnt_q) + SIZE_W'(1)) == req_q.r_size;
  assign size_mismatch = (WSIZE_W'(req_q.r_end - req_q.r_start) + WSIZE_W'(1)) != req_q.w_size;

  fetch_byte_packer u_packer (
    .buffer  (buf_q),
    .r_start (req_q.r_start),
    .r_end   (req_q.r_end),
    .strb    (req_q.w_strb),
    .data    (packed_data)
  );

  // Next state and next registered output values.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    beat_cnt_d = beat_cnt_q;
    buf_we     = 1'b0;
    err_d      = 1'b0;
    wr_addr_d  = o_wr_addr;
    wr_data_d  = o_wr_data;
    wr_strb_d  = o_wr_strb;

    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          if (req_ok) begin
            req_d      = req_in;
            beat_cnt_d = '0;
            state_d    = ST_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (i_ar_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (i_r_valid) begin
          buf_we     = 1'b1;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          // The beat count, not i_r_last, decides when the burst is done.
          if (i_r_last != final_beat) err_d = 1'b1;
          if (final_beat) begin
            state_d = ST_PACK;
            // Raised here so the pulse lands in the PACK cycle.
            if (size_mismatch) err_d = 1'b1;
          end
        end
      end
      ST_PACK: begin
        wr_addr_d = req_q.w_addr;
        wr_data_d = packed_data;
        wr_strb_d = req_q.w_strb;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (i_wr_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // AR fields track the latched request, so they stay stable through stalls.
    ar_addr_d  = req_d.r_addr;
    ar_len_d   = LEN_W'(req_d.r_size - SIZE_W'(1));
    ready_d    = (state_d == ST_IDLE);
    ar_valid_d = (state_d == ST_ADDR);
    r_ready_d  = (state_d == ST_DATA);
    wr_valid_d = (state_d == ST_WRITE);
  end

  // State, request and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      beat_cnt_q <= '0;
      o_ready    <= 1'b1;
      o_ar_valid <= 1'b0;
      o_ar_addr  <= '0;
      o_ar_len   <= '0;
      o_r_ready  <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_wr_strb  <= '0;
      o_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      beat_cnt_q <= beat_cnt_d;
      o_ready    <= ready_d;
      o_ar_valid <= ar_valid_d;
      o_ar_addr  <= ar_addr_d;
      o_ar_len   <= ar_len_d;
      o_r_ready  <= r_ready_d;
      o_wr_valid <= wr_valid_d;
      o_wr_addr  <= wr_addr_d;
      o_wr_data  <= wr_data_d;
      o_wr_strb  <= wr_strb_d;
      o_err      <= err_d;
    end
  end

  // Beat buffer; slots beyond the current burst are never read by the packer.
  always_ff @(posedge i_clk) begin
    if (!i_rst && buf_we) begin
      buf_q[MEM_DATA_W*int'(beat_cnt_q[BEAT_IDX_W-1:0]) +: MEM_DATA_W] <= i_r_data;
    end
  end

endmodule

// File: doc/trid_fetch_unit.md
# trid_fetch_unit

One instance per transaction ID (16 in the relational cache) sitting directly downstream of the requestor. It accepts a column-fetch request (read address, beat count, byte window, write address/strobe) when its enable bit pulses. It then issues a burst read to memory, buffers the returned 128-bit beats, and extracts the requested byte window. Finally it writes those bytes into the 64-byte cache line and reports ready back to the requestor.

## Interface
- ADDR_W, 32, address width
- MEM_DATA_W, 128, memory read beat width (16 bytes)
- LINE_BYTES, 64, cache write line width in bytes
- MAX_BEATS, 8, read buffer depth in beats (128 bytes)

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  request strobe; this unit's bit of the requestor's one-hot enable
- i_r_addr  in  32  read byte address, 16-byte aligned
- i_r_size  in  7  beats to read
- i_r_start / i_r_end  in  7  first/last byte index (inclusive) within the buffered window
- i_w_addr  in  32  cache line write address
- i_w_size  in  16  expected extracted byte count
- i_w_strb  in  64  cache line byte-enable
- o_ready  out  1  idle, can accept a request
- o_ar_valid / i_ar_ready  out/in  1  read-address handshake
- o_ar_addr  out  32 and o_ar_len  out  8  burst address, beats-1
- i_r_valid / o_r_ready  in/out  1  read-data handshake
- i_r_data  in  128 and i_r_last  in  1  beat data, final-beat flag
- o_wr_valid / i_wr_ready  out/in  1  cache write handshake
- o_wr_addr  out  32, o_wr_data  out  512, o_wr_strb  out  64  cache write
- o_err  out  1  one-cycle protocol/range error pulse

## Operation
- FSM states: IDLE, ADDR, DATA, PACK, WRITE.
- **IDLE:** o_ready=1. When i_en=1, latch all i_* request fields and go to ADDR. i_en while not IDLE is ignored.
- **Request validation at accept:**
  - i_r_size==0, i_r_size>MAX_BEATS, i_r_end<i_r_start, i_r_end>=16*i_r_size, or end-start+1>LINE_BYTES → pulse o_err and stay IDLE.
  - Such a request issues no AR and no write.
- **ADDR:** o_ar_valid=1, o_ar_addr=latched addr, o_ar_len=i_r_size-1. Hold all three stable until i_ar_ready. Then go to DATA.
- **DATA:** o_r_ready=1. Each accepted beat is stored in buffer slot beat_cnt, then beat_cnt increments. Go to PACK when beat_cnt reaches i_r_size.
  - i_r_last must coincide with the final counted beat.
  - Early or missing i_r_last → pulse o_err on the offending beat. Counting still governs completion.
- **PACK:** one cycle, no handshakes. Byte packer works as follows:
  - L = index of lowest set bit of the latched strb.
  - For each lane j with strb[j]=1, line byte j = buffer byte (start + j - L) when that index ≤ end; otherwise 0.
  - If end-start+1 != i_w_size, pulse o_err. The write still proceeds.
- **WRITE:** o_wr_valid=1 with registered addr/data/strb, held stable until i_wr_ready. Then return to IDLE.
- **Arithmetic:** byte indices are 7-bit unsigned; beat_cnt is 4-bit; no wrap is possible after validation.
- **Reset:**
  - Any cycle with i_rst=1 forces IDLE, clears beat_cnt, and discards outstanding beats and writes.
  - Reset values: o_ready=1 and all other outputs 0.
  - Beats arriving after a mid-burst reset are a system-level concern; the unit returns o_r_ready=0 and ignores them.

## Timing
- Accept at cycle T (i_en=1 in IDLE):
  - o_ready=0 and o_ar_valid=1 from T+1.
- Zero-wait-state sequence:
  - AR completes at T+1.
  - Beats arrive at T+2 … T+1+N.
  - PACK at T+2+N.
  - o_wr_valid at T+3+N.
  - o_ready=1 at T+4+N.
- Minimum request-to-request spacing: N+4 cycles.
- All outputs are registered; there is no combinational path from i_* to o_*.
- The o_err pulse is exactly one cycle, in the cycle after the triggering event.

## Structure
- Shared package rc_fetch_pkg holds:
  - the state enum (fetch_state_t);
  - ADDR_W, MEM_DATA_W, LINE_BYTES, MAX_BEATS;
  - the request struct (fetch_req_t: r_addr, r_size, r_start, r_end, w_addr, w_size, w_strb), also usable by the requestor side.
- One sub-module, fetch_byte_packer: combinational, taking buffer, start, end and strb to line data. It is separately testable.

## Test plan
- **Single beat.** addr=0x1000, size=1, start=2, end=5, strb=0x0F, w_size=4.
  - Beat data bytes 0..15 = 0x00..0x0F.
  - Expect AR len=0.
  - Expect a write with data bytes 0..3 = 02,03,04,05 and strb 0x0F.
  - o_ready returns at T+5.
- **Four-beat burst with backpressure.** size=4, start=20, end=51, strb=0xFFFFFFFF00000000.
  - i_ar_ready late 3 cycles; i_r_valid gaps.
  - Expect lanes 32..63 = buffer bytes 20..51.
  - AR fields remain stable throughout the stall.
- **Invalid requests.** size=0, then end<start, then size=9.
  - Expect an o_err pulse each time, no o_ar_valid, and o_ready held at 1.
- **Protocol error.** i_r_last asserted on beat 2 of 4.
  - Expect an o_err pulse on that beat.
  - The write is still issued after the 4th beat.
- **Reset in DATA after 2 of 4 beats.**
  - Next cycle: o_ready=1, o_r_ready=0, no write.
  - A new request completes correctly.
- **Size mismatch and busy.** w_size=10 with end-start+1=8.
  - Expect o_err in the PACK cycle; the write proceeds.
  - i_en pulsed while busy is ignored: exactly one AR is issued.
